// File: rtl/cpu_pkg.sv
// Shared decode-side constants: datapath sizing, instruction field positions
// and the NOP control bundle that DX loads whenever decode issues a bubble.
package cpu_pkg;

   localparam int WIDTH     = 16;
   localparam int NREGS     = 8;
   localparam int REG_SEL_W = $clog2(NREGS);

   localparam int RS_MSB = 10;
   localparam int RS_LSB = 8;
   localparam int RT_MSB = 7;
   localparam int RT_LSB = 5;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic branch;
      logic jump;
      logic halt;
      logic [3:0] alu_op;
   } dx_ctrl_t;

   localparam dx_ctrl_t DX_NOP_CTRL = '0;

endpackage

// File: rtl/regfile_bypass.sv
// Architectural register file: one write port, two combinational read ports.
// DECODE_REGFILE_BYPASS_EN adds a same-cycle write-to-read bypass.
module regfile_bypass
   import cpu_pkg::*;
#(
   parameter int NREGS = cpu_pkg::NREGS,
   parameter int WIDTH = cpu_pkg::WIDTH,
   parameter int SEL_W = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SEL_W-1:0] rd1_sel,
   input  logic [SEL_W-1:0] rd2_sel,
   input  logic             wr_en,
   input  logic [SEL_W-1:0] wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd1_data,
   output logic [WIDTH-1:0] rd2_data
);

   logic [WIDTH-1:0] mem [NREGS];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_sel] <= wr_data;
      end
   end

`ifdef DECODE_REGFILE_BYPASS_EN
   always_comb begin
      rd1_data = mem[rd1_sel];
      rd2_data = mem[rd2_sel];
      if (wr_en && (wr_sel == rd1_sel)) begin
         rd1_data = wr_data;
      end
      if (wr_en && (wr_sel == rd2_sel)) begin
         rd2_data = wr_data;
      end
   end
`else
   // Without the bypass, readers see pre-write contents; the top-level
   // hazard logic stalls on MW matches instead.
   always_comb begin
      rd1_data = mem[rd1_sel];
      rd2_data = mem[rd2_sel];
   end
`endif

endmodule

// File: rtl/decode_hazard_stage.sv
// Decode stage: register file, RAW hazard stall/bubble, HALT tracking, stall counter.
// DECODE_REGFILE_BYPASS_EN selects MW bypass; otherwise MW is a third hazard source.
module decode_hazard_stage
   import cpu_pkg::*;
#(
   parameter int NREGS = cpu_pkg::NREGS,
   parameter int WIDTH = cpu_pkg::WIDTH,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [15:0]              FD_instr,
   input  logic                     FD_valid,
   input  logic                     readsRs,
   input  logic                     readsRt,
   input  logic                     isHalt,
   input  logic                     DX_regWrite,
   input  logic [$clog2(NREGS)-1:0] DX_writeReg,
   input  logic                     XM_regWrite,
   input  logic [$clog2(NREGS)-1:0] XM_writeReg,
   input  logic                     MW_regWrite,
   input  logic [$clog2(NREGS)-1:0] MW_writeReg,
   input  logic [WIDTH-1:0]         MW_writeData,
   input  logic                     flush,
   output logic [WIDTH-1:0]         read1Data,
   output logic [WIDTH-1:0]         read2Data,
   output logic                     stall,
   output logic                     bubble,
   output logic                     halted,
   output logic [CNT_W-1:0]         stallCount
);

   localparam int SEL_W = $clog2(NREGS);

   logic [SEL_W-1:0] rs;
   logic [SEL_W-1:0] rt;
   logic             unused_instr_bits;

   assign rs = FD_instr[RS_MSB:RS_LSB];
   assign rt = FD_instr[RT_MSB:RT_LSB];
   assign unused_instr_bits = ^{FD_instr[15:RS_MSB+1], FD_instr[RT_LSB-1:0]};

   regfile_bypass #(
      .NREGS (NREGS),
      .WIDTH (WIDTH),
      .SEL_W (SEL_W)
   ) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .rd1_sel  (rs),
      .rd2_sel  (rt),
      .wr_en    (MW_regWrite),
      .wr_sel   (MW_writeReg),
      .wr_data  (MW_writeData),
      .rd1_data (read1Data),
      .rd2_data (read2Data)
   );

   logic hz_dx_rs, hz_dx_rt;
   logic hz_xm_rs, hz_xm_rt;
   logic hz_mw_rs, hz_mw_rt;
   logic haz;

   // R0 is an ordinary register here, so there is no zero-register exemption.
   assign hz_dx_rs = readsRs & DX_regWrite & (rs == DX_writeReg);
   assign hz_dx_rt = readsRt & DX_regWrite & (rt == DX_writeReg);
   assign hz_xm_rs = readsRs & XM_regWrite & (rs == XM_writeReg);
   assign hz_xm_rt = readsRt & XM_regWrite & (rt == XM_writeReg);

`ifdef DECODE_REGFILE_BYPASS_EN
   assign hz_mw_rs = 1'b0;
   assign hz_mw_rt = 1'b0;
`else
   assign hz_mw_rs = readsRs & MW_regWrite & (rs == MW_writeReg);
   assign hz_mw_rt = readsRt & MW_regWrite & (rt == MW_writeReg);
`endif

   assign haz = FD_valid & ~halted &
                (hz_dx_rs | hz_dx_rt | hz_xm_rs | hz_xm_rt | hz_mw_rs | hz_mw_rt);

   // A resolved branch squashes FD, so stalling it would be pointless.
   assign stall  = haz & ~flush;
   assign bubble = haz | flush | halted | ~FD_valid;

   always_ff @(posedge clk) begin
      if (!rst) begin
         halted <= 1'b0;
      end else if (FD_valid & isHalt & ~stall & ~flush) begin
         halted <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stallCount <= '0;
      end else if (stall && (stallCount != '1)) begin
         stallCount <= stallCount + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_decode_hazard_stage.sv
// Directed-vector bench for decode_hazard_stage; expectations track whether
// DECODE_REGFILE_BYPASS_EN is defined for the build.
module tb_decode_hazard_stage;

`ifdef DECODE_REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [15:0] FD_instr;
   logic        FD_valid, readsRs, readsRt, isHalt;
   logic        DX_regWrite, XM_regWrite, MW_regWrite;
   logic [2:0]  DX_writeReg, XM_writeReg, MW_writeReg;
   logic [15:0] MW_writeData;
   logic        flush;
   logic [15:0] read1Data, read2Data;
   logic        stall, bubble, halted;
   logic [15:0] stallCount;

   int n_checks = 0;
   int n_fail   = 0;

   decode_hazard_stage dut (
      .clk          (clk),
      .rst          (rst),
      .FD_instr     (FD_instr),
      .FD_valid     (FD_valid),
      .readsRs      (readsRs),
      .readsRt      (readsRt),
      .isHalt       (isHalt),
      .DX_regWrite  (DX_regWrite),
      .DX_writeReg  (DX_writeReg),
      .XM_regWrite  (XM_regWrite),
      .XM_writeReg  (XM_writeReg),
      .MW_regWrite  (MW_regWrite),
      .MW_writeReg  (MW_writeReg),
      .MW_writeData (MW_writeData),
      .flush        (flush),
      .read1Data    (read1Data),
      .read2Data    (read2Data),
      .stall        (stall),
      .bubble       (bubble),
      .halted       (halted),
      .stallCount   (stallCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_writers();
      DX_regWrite = 1'b0; DX_writeReg = 3'd0;
      XM_regWrite = 1'b0; XM_writeReg = 3'd0;
      MW_regWrite = 1'b0; MW_writeReg = 3'd0; MW_writeData = 16'h0000;
   endtask

   initial begin
      rst = 1'b0; FD_instr = 16'h0000; FD_valid = 1'b0;
      readsRs = 1'b0; readsRt = 1'b0; isHalt = 1'b0; flush = 1'b0;
      quiet_writers();

      // Reset, then read R3/R5
      next_cycle();
      next_cycle();
      rst = 1'b1;
      FD_instr = 16'h03A0; FD_valid = 1'b1; readsRs = 1'b1; readsRt = 1'b1;
      @(negedge clk);
      chk("rst_rd1", read1Data, 16'h0000);
      chk("rst_rd2", read2Data, 16'h0000);
      chk("rst_stall", stall, 1'b0);
      chk("rst_bubble", bubble, 1'b0);
      chk("rst_cnt", stallCount, 16'd0);
      chk("rst_halted", halted, 1'b0);

      // Back-to-back RAW on R2: producer passes DX, XM, then MW
      next_cycle();
      FD_instr = 16'h0200; readsRs = 1'b1; readsRt = 1'b0;
      DX_regWrite = 1'b1; DX_writeReg = 3'd2;
      @(negedge clk);
      chk("raw_dx_stall", stall, 1'b1);
      chk("raw_dx_bubble", bubble, 1'b1);
      next_cycle();
      DX_regWrite = 1'b0;
      XM_regWrite = 1'b1; XM_writeReg = 3'd2;
      @(negedge clk);
      chk("raw_xm_stall", stall, 1'b1);
      chk("raw_xm_bubble", bubble, 1'b1);
      chk("raw_xm_cnt", stallCount, 16'd1);
      next_cycle();
      XM_regWrite = 1'b0;
      MW_regWrite = 1'b1; MW_writeReg = 3'd2; MW_writeData = 16'h1234;
      @(negedge clk);
      chk("raw_mw_stall", stall, BYP ? 1'b0 : 1'b1);
      chk("raw_mw_bubble", bubble, BYP ? 1'b0 : 1'b1);
      chk("raw_mw_rd1", read1Data, BYP ? 16'h1234 : 16'h0000);
      chk("raw_mw_cnt", stallCount, 16'd2);
      next_cycle();
      quiet_writers();
      @(negedge clk);
      chk("raw_done_stall", stall, 1'b0);
      chk("raw_done_bubble", bubble, 1'b0);
      chk("raw_done_rd1", read1Data, 16'h1234);
      chk("raw_done_cnt", stallCount, BYP ? 16'd2 : 16'd3);

      // Writeback to R4 while FD reads Rt=4
      next_cycle();
      FD_valid = 1'b0; readsRs = 1'b0; readsRt = 1'b0;
      MW_regWrite = 1'b1; MW_writeReg = 3'd4; MW_writeData = 16'h1111;
      @(negedge clk);
      chk("novalid_bubble", bubble, 1'b1);
      next_cycle();
      FD_valid = 1'b1; FD_instr = 16'h0080; readsRt = 1'b1;
      MW_writeData = 16'hBEEF;
      @(negedge clk);
      chk("wb_rd2", read2Data, BYP ? 16'hBEEF : 16'h1111);
      chk("wb_stall", stall, BYP ? 1'b0 : 1'b1);
      next_cycle();
      quiet_writers();
      @(negedge clk);
      chk("wb_after_rd2", read2Data, 16'hBEEF);
      chk("wb_after_stall", stall, 1'b0);
      chk("wb_after_cnt", stallCount, BYP ? 16'd2 : 16'd4);

      // Flush beats the R1 hazard and squashes a simultaneous HALT
      next_cycle();
      FD_instr = 16'h0100; readsRs = 1'b1; readsRt = 1'b0;
      DX_regWrite = 1'b1; DX_writeReg = 3'd1;
      flush = 1'b1; isHalt = 1'b1;
      @(negedge clk);
      chk("flush_stall", stall, 1'b0);
      chk("flush_bubble", bubble, 1'b1);
      next_cycle();
      flush = 1'b0; isHalt = 1'b0; readsRs = 1'b0;
      quiet_writers();
      @(negedge clk);
      chk("flush_halted", halted, 1'b0);
      chk("flush_bubble_clr", bubble, 1'b0);
      chk("flush_cnt", stallCount, BYP ? 16'd2 : 16'd4);

      // Saturation: hold a DX hazard on R3 for 70000 cycles
      next_cycle();
      FD_instr = 16'h0300; readsRs = 1'b1;
      DX_regWrite = 1'b1; DX_writeReg = 3'd3;
      repeat (70000) @(posedge clk);
      #1;
      @(negedge clk);
      chk("sat_stall", stall, 1'b1);
      chk("sat_cnt", stallCount, 16'hFFFF);
      next_cycle();
      @(negedge clk);
      chk("sat_hold", stallCount, 16'hFFFF);

      // Reset mid-stall clears count and register contents
      next_cycle();
      rst = 1'b0;
      next_cycle();
      rst = 1'b1;
      quiet_writers();
      FD_instr = 16'h0200;
      @(negedge clk);
      chk("rstmid_stall", stall, 1'b0);
      chk("rstmid_cnt", stallCount, 16'd0);
      chk("rstmid_rd1", read1Data, 16'h0000);

      // HALT retires, then MW still drains into R7
      next_cycle();
      FD_instr = 16'h0000; readsRs = 1'b0; readsRt = 1'b0; isHalt = 1'b1;
      @(negedge clk);
      chk("halt_pre_halted", halted, 1'b0);
      chk("halt_pre_bubble", bubble, 1'b0);
      next_cycle();
      isHalt = 1'b0;
      FD_instr = 16'h0700; readsRs = 1'b1;
      DX_regWrite = 1'b1; DX_writeReg = 3'd7;
      MW_regWrite = 1'b1; MW_writeReg = 3'd7; MW_writeData = 16'h0042;
      @(negedge clk);
      chk("halt_halted", halted, 1'b1);
      chk("halt_stall", stall, 1'b0);
      chk("halt_bubble", bubble, 1'b1);
      next_cycle();
      quiet_writers();
      @(negedge clk);
      chk("halt_r7", read1Data, 16'h0042);
      chk("halt_bubble2", bubble, 1'b1);
      chk("halt_sticky", halted, 1'b1);
      chk("halt_cnt", stallCount, 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_hazard_stage.md
Name: decode_hazard_stage

Overview:
- Decode stage directly upstream of the DX pipeline register.
- Holds the 8x16 architectural register file and supplies both operands to DX.
- Detects RAW hazards against in-flight DX/XM writers (demo2 has no forwarding), stalls fetch/FD and injects a bubble into DX.
- Tracks HALT retirement at decode and counts stall cycles.

Parameters:
- NREGS, 8, register count; select width is clog2(NREGS)=3.
- WIDTH, 16, datapath width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- FD_instr  in  16  instruction from FD register; Rs=[10:8], Rt=[7:5].
- FD_valid  in  1  FD holds a real instruction.
- readsRs  in  1  instruction consumes Rs (from control unit).
- readsRt  in  1  instruction consumes Rt.
- isHalt  in  1  instruction is HALT.
- DX_regWrite  in  1  DX-stage instruction writes a register (already valid-qualified).
- DX_writeReg  in  3  DX destination.
- XM_regWrite  in  1  XM-stage instruction writes a register.
- XM_writeReg  in  3  XM destination.
- MW_regWrite  in  1  writeback enable.
- MW_writeReg  in  3  writeback destination.
- MW_writeData  in  16  writeback data.
- flush  in  1  taken branch/jump resolved downstream; squash FD contents.
- read1Data  out  16  Rs operand to DX.
- read2Data  out  16  Rt operand to DX.
- stall  out  1  hold PC and FD register this cycle.
- bubble  out  1  DX must load NOP controls this cycle.
- halted  out  1  HALT has passed decode.
- stallCount  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (rst==0 at posedge):
  - All registers, halted and stallCount clear to 0.
  - read1Data and read2Data therefore read 0.
  - stall and bubble are 0 after reset.
- Register file:
  - Write at posedge when MW_regWrite is 1.
  - Reads are combinational.
  - Same-cycle read of MW_writeReg returns MW_writeData (write-before-read bypass).
- Hazard terms:
  - hzA = readsRs & DX_regWrite & (Rs==DX_writeReg), same for XM, likewise for Rt.
  - haz = FD_valid & ~halted & (any term).
  - R0 is a normal register; no zero exemption.
- Outputs:
  - stall = haz & ~flush.
  - bubble = haz | flush | halted | ~FD_valid.
- Priority:
  - flush beats stall: no stall when flush=1, even if haz=1.
  - Simultaneous flush and isHalt: HALT is squashed and halted stays 0.
- Latency: a dependent instruction stalls until its producer leaves XM. Worst case is 2 stall cycles (back-to-back producer/consumer); 1 cycle with one independent instruction between them.
- halted:
  - Sets at posedge when FD_valid & isHalt & ~stall & ~flush.
  - Sticky until reset; while set, every cycle is a bubble.
  - The register file still accepts MW writes so older instructions drain.
- stallCount:
  - Increments by 1 at posedge when stall=1.
  - Saturates at all-ones; no wrap.
- Reset mid-stall: the next cycle has stall=0, and register contents are lost.

Optional Feature:
- Macro: DECODE_REGFILE_BYPASS_EN.
- Defined: MW same-cycle write-to-read bypass as above.
- Undefined:
  - No internal bypass; reads return pre-write contents.
  - MW becomes a third hazard source (MW_regWrite & match), giving a worst-case stall of 3 cycles.

Decomposition:
- Shared package cpu_pkg:
  - WIDTH, NREGS, REG_SEL_W constants.
  - RS_MSB/RS_LSB and RT_MSB/RT_LSB field position constants.
  - The NOP control bundle constant that DX loads on a bubble.
- One sub-module, regfile_bypass:
  - Contents: storage array, write port, two read ports, macro-controlled bypass.
  - Hazard logic, halt flag and counter stay at top level.

Test Plan:
- Reset then read: rst=0 for 2 cycles, then FD_instr reading R3,R5 -> read1Data=0, read2Data=0, stall=0, stallCount=0.
- Back-to-back RAW:
  - Stimulus: DX_regWrite=1, DX_writeReg=2, then XM next cycle, with FD Rs=2, readsRs=1.
  - Required: stall=1 and bubble=1 for exactly 2 cycles, then 0; stallCount=2.
- Writeback bypass: MW_regWrite=1, MW_writeReg=4, MW_writeData=16'hBEEF in the same cycle FD reads Rt=4 -> read2Data=16'hBEEF that cycle, with the macro defined.
  - Without the macro: read2Data equals the old R4 contents and stall=1.
- Flush priority: haz on Rs=1 with flush=1 -> stall=0, bubble=1; FD not held.
- Halt:
  - Stimulus: isHalt=1 with FD_valid=1 and no hazard, followed by any instructions.
  - Required: halted=1 after that edge; bubble=1 every later cycle; MW write to R7=16'h0042 still lands, and a read of R7 returns 16'h0042.
- Saturation: force 70000 consecutive stall cycles with CNT_W=16 -> stallCount holds at 16'hFFFF.
